// File: rtl/mem_pkg.sv
// Shared constants, FSM state encoding and the load-extension helper for the
// RV32 data memory with UART/hardware-counter MMIO.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] DEF_UART_ADDR = 32'hf6ff_f070;
    localparam logic [31:0] DEF_HC_ADDR   = 32'hffff_ff00;
    localparam logic [31:0] DEF_STAT_ADDR = 32'hf6ff_f074;

    typedef enum logic [1:0] {IDLE, LAUNCH, GUARD, WAIT} drain_state_e;

    // Decode context carried from acceptance to the response cycle.
    typedef struct packed {
        logic       sel_mmio;
        logic [2:0] f3;
        logic [1:0] off;
    } rsp_ctl_t;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_BU:   return {24'h0, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_HU:   return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between MMIO stores and the UART drain FSM; pointers carry an
// extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] store_q [DEPTH];
    logic             do_push, do_pop;

    // A push while full is only legal alongside a pop that frees the slot.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = store_q[rd_ptr[PW-2:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr[PW-2:0]] <= din;
    end

endmodule

// File: rtl/data_memory_mmio.sv
// RV32 data memory: byte-lane RAM with registered 1-cycle loads, HC/status
// MMIO reads and a buffered UART TX path drained by a small FSM.
module data_memory_mmio
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 33001,
    parameter logic [31:0] UART_ADDR   = DEF_UART_ADDR,
    parameter logic [31:0] HC_ADDR     = DEF_HC_ADDR,
    parameter logic [31:0] STAT_ADDR   = DEF_STAT_ADDR,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_busy,
    input  logic [31:0] hc_data
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

    // ---------------- request decode ----------------
    logic [1:0]    off;
    logic          is_uart, is_hc, is_stat, is_mmio, in_mem;
    logic          is_b, is_h, is_w, f3_ok, misaligned, acc_err;
    logic          fire, mem_we, mem_rd, fifo_push;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_sh, stat_word;
    logic [AW-1:0] widx;
    logic [1:0]    vld_pipe;

    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    assign off     = req_addr[1:0];
    assign widx    = req_addr[AW+1:2];
    assign is_uart = (req_addr == UART_ADDR);
    assign is_hc   = (req_addr == HC_ADDR);
    assign is_stat = (req_addr == STAT_ADDR);
    assign is_mmio = is_uart || is_hc || is_stat;
    assign in_mem  = (req_addr < MEM_BYTES);

    assign is_b       = (req_funct3 == F3_B) || (!req_we && req_funct3 == F3_BU);
    assign is_h       = (req_funct3 == F3_H) || (!req_we && req_funct3 == F3_HU);
    assign is_w       = (req_funct3 == F3_W);
    assign f3_ok      = is_b || is_h || is_w;
    assign misaligned = (is_h && off == 2'd3) || (is_w && off != 2'd0);

    always_comb begin
        acc_err = 1'b0;
        if (!f3_ok)
            acc_err = 1'b1;
        else if (is_mmio) begin
            // UART is store-only (byte or word); HC/STAT are word-read-only.
            if (req_we) acc_err = !is_uart || !(req_funct3 == F3_B || is_w);
            else        acc_err = is_uart || !is_w;
        end else
            acc_err = !in_mem || misaligned;
    end

    assign req_ready = !(req_we && is_uart && fifo_full);
    assign fire      = req_valid && req_ready;
    assign mem_we    = fire && req_we && !acc_err && !is_mmio;
    assign mem_rd    = fire && !req_we && !is_mmio && in_mem;
    assign fifo_push = fire && req_we && is_uart && !acc_err;
    assign vld_pipe[0] = fire && !req_we;

    always_comb begin
        byte_en = 4'h0;
        if (is_b)      byte_en = 4'b0001 << off;
        else if (is_h) byte_en = 4'b0011 << off;
        else if (is_w) byte_en = 4'b1111;
    end
    assign wdata_sh  = req_wdata << {off, 3'b000};
    assign stat_word = 32'({fifo_count, fifo_full, fifo_empty});

    // ---------------- storage (never reset) ----------------
    logic [3:0][7:0] mem_q [DEPTH_WORDS];
    logic [31:0]     mem_word_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we && byte_en[i]) mem_q[widx][i] <= wdata_sh[8*i +: 8];
        if (mem_rd) mem_word_q <= mem_q[widx];
    end

    // ---------------- response ----------------
    rsp_ctl_t    ctl_q;
    logic        err_q;
    logic [31:0] mmio_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            err_q       <= 1'b0;
            ctl_q       <= '0;
            mmio_q      <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            err_q       <= fire && acc_err;
            if (vld_pipe[0]) begin
                ctl_q <= '{sel_mmio: is_mmio, f3: req_funct3, off: off};
                if (is_mmio) mmio_q <= is_hc ? hc_data : stat_word;
            end
        end
    end

    assign rsp_valid = vld_pipe[1];
    assign rsp_err   = err_q;
    assign rsp_rdata = (vld_pipe[1] && !err_q)
                     ? (ctl_q.sel_mmio ? mmio_q : load_extend(mem_word_q, ctl_q.f3, ctl_q.off))
                     : 32'h0;

    // ---------------- UART TX path ----------------
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (req_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    drain_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && !uart_tx_busy) state_d = LAUNCH;
            LAUNCH:  state_d = GUARD;
            // busy only rises the cycle after the pulse, so skip one look
            GUARD:   state_d = WAIT;
            WAIT:    if (!uart_tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop      = (state_q == IDLE) && !fifo_empty && !uart_tx_busy;
        uart_tx_valid = (state_q == LAUNCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        uart_tx_data <= 8'h0;
        else if (fifo_pop) uart_tx_data <= fifo_dout;
    end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: loads/stores, errors, MMIO, UART drain
// timing against a 10-cycle-busy UART model, and reset mid-transfer.
module tb_data_memory_mmio;
    import mem_pkg::*;

    localparam int          DEPTH_WORDS = 33001;
    localparam logic [31:0] UART = 32'hf6ff_f070;
    localparam logic [31:0] HC   = 32'hffff_ff00;
    localparam logic [31:0] STAT = 32'hf6ff_f074;
    localparam logic [31:0] TOP  = 32'(4 * DEPTH_WORDS);

    logic        clk, rst_n;
    logic        req_valid, req_we, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, uart_tx_busy;
    logic [31:0] hc_data;

    int n_cmp = 0;
    int n_bad = 0;

    data_memory_mmio #(
        .DEPTH_WORDS(DEPTH_WORDS), .UART_ADDR(UART), .HC_ADDR(HC),
        .STAT_ADDR(STAT), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_busy(uart_tx_busy), .hc_data(hc_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy for 10 cycles starting the cycle after each pulse.
    int   cyc = 0;
    int   bcnt = 0;
    logic force_busy;
    logic [7:0] pq[$];
    int         pt[$];

    assign uart_tx_busy = force_busy || (bcnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_tx_valid) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
        if (uart_tx_valid) begin
            pq.push_back(uart_tx_data);
            pt.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request for one cycle (starts just after a negedge), sample at next negedge.
    task automatic access(input logic we, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, output logic rdy, output logic [31:0] rd,
                          output logic err, output logic vld);
        req_valid = 1'b1; req_we = we; req_addr = a; req_funct3 = f3; req_wdata = wd;
        #1 rdy = req_ready;
        @(negedge clk);
        rd = rsp_rdata; err = rsp_err; vld = rsp_valid;
        req_valid = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] exp_rd, input logic exp_err);
        logic rdy, err, vld;
        logic [31:0] rd;
        access(1'b0, a, f3, 32'h0, rdy, rd, err, vld);
        chk({tag, ".rdy"}, 32'(rdy), 32'd1);
        chk({tag, ".vld"}, 32'(vld), 32'd1);
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".rd"},  rd, exp_rd);
    endtask

    task automatic st(input string tag, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, input logic exp_err);
        logic rdy, err, vld;
        logic [31:0] rd;
        access(1'b1, a, f3, wd, rdy, rd, err, vld);
        chk({tag, ".rdy"}, 32'(rdy), 32'd1);
        chk({tag, ".vld"}, 32'(vld), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        int base;
        rst_n = 1'b0; force_busy = 1'b0; hc_data = 32'h0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_funct3 = 3'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0);
        chk("rst.rsp_err",   32'(rsp_err), 32'd0);
        chk("rst.tx_valid",  32'(uart_tx_valid), 32'd0);
        chk("rst.tx_data",   32'(uart_tx_data), 32'h0);
        rst_n = 1'b1;

        // sizes, signs and offsets
        st("sw100",  32'h100, F3_W,  32'h1122_3344, 1'b0);
        ld("lb103",  32'h103, F3_B,  32'h0000_0011, 1'b0);
        ld("lbu103", 32'h103, F3_BU, 32'h0000_0011, 1'b0);
        ld("lh102",  32'h102, F3_H,  32'h0000_1122, 1'b0);
        ld("lhu102", 32'h102, F3_HU, 32'h0000_1122, 1'b0);
        ld("lb100",  32'h100, F3_B,  32'h0000_0044, 1'b0);
        st("sb101",  32'h101, F3_B,  32'h0000_0080, 1'b0);
        ld("lb101",  32'h101, F3_B,  32'hFFFF_FF80, 1'b0);
        ld("lbu101", 32'h101, F3_BU, 32'h0000_0080, 1'b0);
        ld("lw100",  32'h100, F3_W,  32'h1122_8044, 1'b0);
        ld("lh100",  32'h100, F3_H,  32'hFFFF_8044, 1'b0);
        ld("lh101",  32'h101, F3_H,  32'h0000_2280, 1'b0);

        // errors and boundaries
        ld("lw102",  32'h102, F3_W,  32'h0, 1'b1);
        st("sh103",  32'h103, F3_H,  32'h0000_ABCD, 1'b1);
        ld("lw100b", 32'h100, F3_W,  32'h1122_8044, 1'b0);
        st("sw_f3bad", 32'h100, 3'b011, 32'hFFFF_FFFF, 1'b1);
        ld("ld_f3bad", 32'h100, 3'b011, 32'h0, 1'b1);
        ld("lw100c", 32'h100, F3_W,  32'h1122_8044, 1'b0);
        ld("lwtop",  TOP,         F3_W, 32'h0, 1'b1);
        st("swtop",  TOP,         F3_W, 32'h1234_5678, 1'b1);
        st("swlast", TOP - 32'd4, F3_W, 32'h5A5A_A5A5, 1'b0);
        ld("lwlast", TOP - 32'd4, F3_W, 32'h5A5A_A5A5, 1'b0);
        st("sh_u",   32'h200, F3_H, 32'h0000_BEEF, 1'b0);
        ld("lhu_u",  32'h200, F3_HU, 32'h0000_BEEF, 1'b0);

        // MMIO reads
        hc_data = 32'hDEAD_BEEF;
        ld("lw_hc",   HC,   F3_W, 32'hDEAD_BEEF, 1'b0);
        ld("lb_hc",   HC,   F3_B, 32'h0, 1'b1);
        st("sw_hc",   HC,   F3_W, 32'h1, 1'b1);
        ld("lw_uart", UART, F3_W, 32'h0, 1'b1);
        ld("lh_stat", STAT, F3_H, 32'h0, 1'b1);

        // fill FIFO while UART held busy
        force_busy = 1'b1;
        st("sh_uart", UART, F3_H, 32'h41, 1'b1);
        ld("stat0",   STAT, F3_W, 32'h0000_0001, 1'b0);
        base = pq.size();
        for (int i = 0; i < 16; i++)
            st($sformatf("push%0d", i), UART, (i % 2 == 0) ? F3_B : F3_W, 32'h41 + 32'(i), 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = UART; req_funct3 = F3_B; req_wdata = 32'h51;
        #1 chk("push17.rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        ld("stat_full", STAT, F3_W, 32'h0000_0042, 1'b0);
        chk("held.pulses", 32'(pq.size() - base), 32'd0);

        force_busy = 1'b0;
        for (int i = 0; i < 300 && pq.size() - base < 16; i++) @(negedge clk);
        chk("drain.count", 32'(pq.size() - base), 32'd16);
        for (int i = 0; i < 16 && base + i < pq.size(); i++)
            chk($sformatf("drain.byte%0d", i), 32'(pq[base + i]), 32'h41 + 32'(i));

        // three bytes, spacing against the busy model
        base = pq.size();
        st("px", UART, F3_B, 32'h78, 1'b0);
        st("py", UART, F3_B, 32'h79, 1'b0);
        st("pz", UART, F3_B, 32'h7A, 1'b0);
        for (int i = 0; i < 100 && pq.size() - base < 3; i++) @(negedge clk);
        chk("three.count", 32'(pq.size() - base), 32'd3);
        if (pq.size() - base >= 3) begin
            chk("three.gap1", 32'(pt[base + 1] - pt[base] >= 12), 32'd1);
            chk("three.gap2", 32'(pt[base + 2] - pt[base + 1] >= 12), 32'd1);
            chk("three.last", 32'(pq[base + 2]), 32'h7A);
        end
        repeat (20) @(negedge clk);
        #1;
        ld("stat_empty", STAT, F3_W, 32'h0000_0001, 1'b0);

        // reset while the FSM waits with 5 bytes queued
        st("sw_keep", 32'h200, F3_W, 32'hCAFE_F00D, 1'b0);
        base = pq.size();
        for (int i = 0; i < 6; i++)
            st($sformatf("q%0d", i), UART, F3_B, 32'h61 + 32'(i), 1'b0);
        chk("pre_rst.pulses", 32'(pq.size() - base), 32'd1);
        ld("stat_q5", STAT, F3_W, 32'h0000_0014, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.tx_valid", 32'(uart_tx_valid), 32'd0);
        chk("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("post_rst.pulses", 32'(pq.size() - base), 32'd1);
        ld("stat_post", STAT, F3_W, 32'h0000_0001, 1'b0);
        ld("lw_keep",   32'h200, F3_W, 32'hCAFE_F00D, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
